// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants, S-box and byte-order helpers
// State packing: byte i at bits 8i+7:8i, column c = bytes 4c..4c+3 (row = i % 4).
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [127:0] aes_key_t;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    // Entry 0 sits at the MSB so the literal reads in FIPS-197 table order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // 255-b == ~b, so the MSB-first entry for b starts at bit 8*(~b).
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(4*c+row) +: 8] = s[8*(4*((c+row)%4)+row) +: 8];
            end
        end
        return r;
    endfunction

    // FIPS-197 hex strings put byte 0 leftmost; the state keeps it at the LSB.
    function automatic aes_state_t to_state(input logic [127:0] fips);
        aes_state_t s;
        for (int i = 0; i < 16; i++) s[8*i +: 8] = fips[8*(15-i) +: 8];
        return s;
    endfunction

    function automatic logic [127:0] from_state(input aes_state_t s);
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*(15-i) +: 8] = s[8*i +: 8];
        return f;
    endfunction

    function automatic bit nr_is_legal(input int nr);
        return (nr == AES128_NR) || (nr == AES192_NR) || (nr == AES256_NR);
    endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// rtl/aes_round_datapath.sv - one AES round body without AddRoundKey
// state_i : current state
// final_i : last round, MixColumns bypassed
// state_o : SubBytes -> ShiftRows -> (MixColumns unless final_i)
module aes_round_datapath
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic         final_i,
    output logic [127:0] state_o
);

    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] mixed;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign sub_bytes[8*i +: 8] = sbox(state_i[8*i +: 8]);
    end

    assign shifted = shift_rows(sub_bytes);

    mix_columns u_mix_columns (
        .state_i (shifted),
        .state_o (mixed)
    );

    assign state_o = final_i ? shifted : mixed;

endmodule

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - AES MixColumns over a packed 128-bit state
// state_i : input state (column c = bytes 4c..4c+3)
// state_o : mixed state, same packing
module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = state_i[32*c      +: 8];
        assign a1 = state_i[32*c + 8  +: 8];
        assign a2 = state_i[32*c + 16 +: 8];
        assign a3 = state_i[32*c + 24 +: 8];
        // 3*x is written as xtime(x) ^ x
        assign state_o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign state_o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign state_o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign state_o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES encryptor, one round per clock
// clk, rst             : clock, synchronous active-high reset
// in_valid/in_ready    : plaintext handshake, in_block is the plaintext state
// rk_addr/rk_data      : round-key index out, key returned same cycle
// out_valid/out_ready  : ciphertext handshake, out_block is the ciphertext state
// busy                 : block in flight or waiting to be taken
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    if (!nr_is_legal(NR)) begin : g_nr_check
        $fatal(1, "aes_round_sequencer: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_CNT = 4'(NR);

    seq_state_e   fsm_q;
    logic [3:0]   cnt_q;
    logic [3:0]   rk_addr_q;
    logic [127:0] blk_q;
    logic         out_valid_q;
    logic         busy_q;
    logic [127:0] round_out;
    logic [127:0] blk_round_d;
    logic         accept;

    aes_round_datapath u_datapath (
        .state_i (blk_q),
        .final_i (cnt_q == NR_CNT),
        .state_o (round_out)
    );

    assign blk_round_d = round_out ^ rk_data;

    // DONE re-arms in_ready when the consumer drains, so back-to-back blocks
    // see no bubble; rk_addr is already 0 there for the initial key add.
    assign in_ready = ~rst & ((fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= 4'd0;
            rk_addr_q   <= 4'd0;
            blk_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (accept) begin
                        blk_q     <= in_block ^ rk_data;
                        cnt_q     <= 4'd1;
                        rk_addr_q <= 4'd1;
                        busy_q    <= 1'b1;
                        fsm_q     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    blk_q <= blk_round_d;
                    if (cnt_q == NR_CNT) begin
                        // counter parks at NR; rk_addr drops to 0 for DONE
                        rk_addr_q   <= 4'd0;
                        out_valid_q <= 1'b1;
                        fsm_q       <= ST_DONE;
                    end else begin
                        cnt_q     <= cnt_q + 4'd1;
                        rk_addr_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            blk_q     <= in_block ^ rk_data;
                            cnt_q     <= 4'd1;
                            rk_addr_q <= 4'd1;
                            fsm_q     <= ST_ROUND;
                        end else begin
                            cnt_q  <= 4'd0;
                            busy_q <= 1'b0;
                            fsm_q  <= ST_IDLE;
                        end
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign rk_addr   = rk_addr_q;
    assign out_valid = out_valid_q;
    assign out_block = blk_q;
    assign busy      = busy_q;

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter: NR, 10, number of AES rounds (10/12/14 legal; others SHALL be rejected at elaboration).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  plaintext block offered.
REQ-005 in_ready  out  1  block accepted when in_valid & in_ready at a rising edge.
REQ-006 in_block  in  128  plaintext state, same byte packing as the mix_columns block (byte i at bits 8i+7:8i, column c = bytes 4c..4c+3).
REQ-007 rk_addr  out  4  round-key index requested from the external key store.
REQ-008 rk_data  in  128  round key for rk_addr, combinational same-cycle return.
REQ-009 out_valid  out  1  ciphertext available.
REQ-010 out_ready  in  1  consumer accepts ciphertext when out_valid & out_ready.
REQ-011 out_block  out  128  ciphertext, same packing as in_block.
REQ-012 busy  out  1  high in ROUND or DONE.

Function
REQ-013 FSM states SHALL be IDLE, ROUND, DONE; one round SHALL complete per clock.
REQ-014 IDLE: rk_addr=0; in_ready=1; on accept, state_reg <= in_block ^ rk_data, round_cnt <= 1, go to ROUND.
REQ-015 ROUND: rk_addr=round_cnt; state_reg <= round(state_reg) ^ rk_data; round_cnt increments.
REQ-016 round() SHALL be SubBytes, ShiftRows, MixColumns for round_cnt 1..NR-1; MixColumns bypassed when round_cnt==NR.
REQ-017 ROUND with round_cnt==NR SHALL transition to DONE; round_cnt SHALL never exceed NR (4-bit counter, no wrap).
REQ-018 Latency: accept edge at cycle 0 -> out_valid high from cycle NR+1; throughput one block per NR+1 cycles when out_ready is held high.
REQ-019 DONE: out_valid=1, out_block=state_reg, held stable until out_ready.
REQ-020 DONE & out_ready & ~in_valid -> IDLE.
REQ-021 DONE & out_ready & in_valid: in_ready=1, new block accepted same edge (rk_addr=0 in DONE), go directly to ROUND; no bubble.
REQ-022 in_ready SHALL be 0 in ROUND, and in DONE while out_ready=0; in_valid in ROUND SHALL be ignored with no state change.
REQ-023 out_valid SHALL be 0 in IDLE and ROUND; out_ready outside DONE SHALL have no effect.
REQ-024 rk_addr SHALL be a pure function of state and round_cnt (no dependency on in_valid/out_ready).

Reset
REQ-025 rst high at an edge SHALL force IDLE, round_cnt=0, state_reg=0 regardless of state; a block in flight SHALL be discarded without out_valid.
REQ-026 Outputs during/after reset: in_ready=1 only after rst deasserted (0 while rst high), out_valid=0, busy=0, rk_addr=0, out_block=0.

Structure
REQ-027 Shared package aes_pkg SHALL hold: state/key 128-bit typedefs, NR legal-value constants, FSM state enum, S-box table, shift_rows function, and FIPS-197 byte-order conversion functions to_state/from_state.
REQ-028 One sub-module aes_round_datapath SHALL implement round() (SubBytes, ShiftRows, instantiated mix_columns, final-round bypass mux); the sequencer holds only FSM, counter, register, handshake.

Verification
REQ-029 FIPS-197 C.1: key 000102..0f expanded by bench, plaintext 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 11 after accept.
REQ-030 Backpressure: out_ready=0 for 5 cycles in DONE -> out_block and out_valid stable, in_ready=0, then single transfer on out_ready=1.
REQ-031 Back-to-back: in_valid and out_ready held high for 4 blocks -> outputs every 11 cycles, rk_addr sequence 0,1..10,0,1.. with no gap.
REQ-032 Reset mid-round: rst asserted at round_cnt=5 -> next cycle IDLE, out_valid=0, rk_addr=0; following block encrypts correctly.
REQ-033 in_valid toggled during ROUND with different data -> ignored; ciphertext matches first block only.
REQ-034 NR=14 with FIPS-197 C.3 key/plaintext -> 8ea2b7ca516745bfeafc49904b496089, out_valid at cycle 15.
